// File: rtl/afifo_pkg.sv
// Shared defaults and state encoding for the FIFO read-side stream adapter.
package afifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/tail buffer between the FIFO read port and a valid/ready stream.
module rd_skid_buf
  import afifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] rdata,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             pop,
  output logic             full
);
  rd_state_t        state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (push) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_d = S_TWO;
        else if (!push && pop) state_d = S_EMPTY;
      end
      S_TWO:   if (pop && !push) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Head always carries the oldest word; tail only matters in S_TWO.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      S_EMPTY: if (push) head_d = rdata;
      S_ONE: begin
        if (push && pop) head_d = rdata;
        else if (push)   tail_d = rdata;
      end
      S_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    full      = (state_q == S_TWO);
    out_data  = head_q;
    pop       = out_valid && out_ready;
  end
endmodule

// File: rtl/afifo_rd_stream.sv
// FIFO read-side adapter: pops the async FIFO into a skid buffer and counts delivered words.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [CNT_W-1:0] pop_count
);
  logic             pop, full;
  logic [CNT_W-1:0] pop_count_q, pop_count_d;

  // Gating with rrst_n keeps the pop strobe low during reset even if the FIFO reports data.
  assign rinc = rrst_n && !rempty && (!full || out_ready);

  rd_skid_buf #(.DSIZE(DSIZE)) u_buf (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .push      (rinc),
    .rdata     (rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop       (pop),
    .full      (full)
  );

  assign pop_count_d = pop ? pop_count_q + 1'b1 : pop_count_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) pop_count_q <= '0;
    else         pop_count_q <= pop_count_d;
  end

  assign pop_count = pop_count_q;
endmodule

// File: tb/tb_afifo_rd_stream.sv
// Randomized bench for afifo_rd_stream against a queue-based model of the stream adapter.
module tb_afifo_rd_stream;
  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        out_ready;
  logic        rinc, out_valid;
  logic [7:0]  out_data;
  logic [15:0] pop_count;
  logic        rinc_s, out_valid_s;
  logic [7:0]  out_data_s;
  logic [2:0]  pop_count_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] src[$];   // words held by the FIFO
  logic [7:0] mbuf[$];  // words held by the adapter
  int         mcount;
  int         rinc_seen;
  logic [7:0] got[$];

  always #5 rclk = ~rclk;

  afifo_rd_stream dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .pop_count(pop_count)
  );

  // Narrow counter instance sharing the stimulus, so counter wrap is reached quickly.
  afifo_rd_stream #(.DSIZE(8), .CNT_W(3)) dut_s (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .pop_count(pop_count_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; compares at negedge, then advances the model across the next posedge.
  task automatic step();
    logic e_rinc, e_pop;
    rempty = (src.size() == 0);
    rdata  = rempty ? 8'($urandom) : src[0];
    @(negedge rclk);
    e_rinc = (src.size() != 0) && (mbuf.size() < 2 || out_ready);
    e_pop  = (mbuf.size() != 0) && out_ready;
    chk("rinc", 32'(rinc), 32'(e_rinc));
    chk("out_valid", 32'(out_valid), 32'(mbuf.size() != 0));
    if (mbuf.size() != 0) chk("out_data", 32'(out_data), 32'(mbuf[0]));
    chk("pop_count", 32'(pop_count), 32'(mcount % 65536));
    chk("pop_count_wrap", 32'(pop_count_s), 32'(mcount % 8));
    if (rinc) rinc_seen++;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge rclk);
    if (e_pop) begin void'(mbuf.pop_front()); mcount++; end
    if (e_rinc) mbuf.push_back(src.pop_front());
    #1;
  endtask

  initial begin
    logic [7:0] nextv;
    rrst_n = 1'b0; rempty = 1'b0; rdata = 8'hA5; out_ready = 1'b1;
    mcount = 0;
    repeat (3) @(posedge rclk);
    #1;
    chk("reset_rinc", 32'(rinc), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_count", 32'(pop_count), 32'd0);
    rrst_n = 1'b1;

    // Streaming 01..04 with ready held high
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    rinc_seen = 0; got.delete();
    repeat (6) step();
    chk("stream_rinc_pulses", 32'(rinc_seen), 32'd4);
    chk("stream_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("stream_word", 32'(got[i]), 32'(i + 1));
    chk("stream_count", 32'(pop_count), 32'd4);

    // Backpressure: only two words may be taken while stalled
    src = '{8'h10, 8'h11, 8'h12, 8'h13};
    out_ready = 1'b0; rinc_seen = 0; got.delete();
    repeat (5) step();
    chk("bp_rinc_pulses", 32'(rinc_seen), 32'd2);
    chk("bp_head", 32'(out_data), 32'h10);
    chk("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (6) step();
    chk("bp_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("bp_word", 32'(got[i]), 32'(8'h10 + i));
    chk("bp_count", 32'(pop_count), 32'd8);

    // Random traffic
    nextv = 8'h40;
    for (int c = 0; c < 600; c++) begin
      if (src.size() < 6 && $urandom_range(0, 2) != 0) begin
        src.push_back(nextv); nextv++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    repeat (10) step();

    // Mid-operation reset with two words buffered
    src = '{8'h30, 8'h31, 8'h32, 8'h33};
    out_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_full_head", 32'(out_data), 32'h30);
    #1 rrst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(pop_count), 32'd0);
    chk("async_rst_rinc", 32'(rinc), 32'd0);
    mbuf.delete(); mcount = 0;
    rrst_n = 1'b1;
    out_ready = 1'b1; got.delete();
    repeat (6) step();
    chk("post_rst_n", 32'(got.size()), 32'd2);
    if (got.size() > 0) chk("post_rst_first", 32'(got[0]), 32'h32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/afifo_rd_stream.md
AFIFO_RD_STREAM -- requirements
Module: afifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8, data word width shared with the FIFO.
REQ-002 Parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 Clocking is fixed: one clock, rclk; reset rrst_n is asynchronous, active-low.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 rempty  input  1  FIFO empty flag; when low, rdata holds the oldest FIFO word.
REQ-007 rdata  input  DSIZE  FIFO head word, valid whenever rempty is low.
REQ-008 rinc  output  1  FIFO pop strobe; one word is consumed per rclk edge with rinc high.
REQ-009 out_valid  output  1  downstream stream valid.
REQ-010 out_ready  input  1  downstream stream ready.
REQ-011 out_data  output  DSIZE  downstream stream data.
REQ-012 pop_count  output  CNT_W  count of words delivered downstream.

Function
REQ-013 The block SHALL hold FIFO words in a 2-entry buffer (head, tail) tracked by FSM states S_EMPTY, S_ONE, S_TWO.
REQ-014 push = rinc; pop = out_valid && out_ready; both SHALL be evaluated on the same rclk edge.
REQ-015 rinc SHALL be combinational: rrst_n && !rempty && (state != S_TWO || out_ready).
REQ-016 S_EMPTY: push -> S_ONE (head <= rdata); otherwise stay.
REQ-017 S_ONE: push only -> S_TWO (tail <= rdata); pop only -> S_EMPTY; push and pop -> S_ONE (head <= rdata).
REQ-018 S_TWO: pop only -> S_ONE (head <= tail); push and pop -> S_TWO (head <= tail, tail <= rdata); no pop -> stay, rinc low.
REQ-019 out_valid SHALL be high exactly when state != S_EMPTY; out_data SHALL equal head.
REQ-020 Words SHALL leave in FIFO order, with none lost or duplicated.
REQ-021 Latency SHALL be one rclk edge: a word popped on edge N is on out_data after edge N.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL remain stable.
REQ-023 Sustained throughput SHALL be one word per rclk when rempty is low and out_ready is high.
REQ-024 pop_count SHALL increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
REQ-025 rempty rising while a word is buffered SHALL NOT affect buffered words or out_valid.

Reset
REQ-026 While rrst_n is low: state is S_EMPTY, out_valid 0, out_data 0, head/tail 0, pop_count 0, rinc 0.
REQ-027 Reset asserted mid-transfer SHALL discard buffered words immediately and asynchronously, without waiting for rclk.
REQ-028 The first push SHALL occur no earlier than the first rclk edge after rrst_n deasserts.

Structure
REQ-029 Shared package afifo_pkg SHALL hold: the DSIZE default, the CNT_W default, and typedef rd_state_t {S_EMPTY, S_ONE, S_TWO}.
REQ-030 The 2-entry buffer plus FSM SHALL be a sub-module rd_skid_buf; the top adds the rinc logic and pop_count.

Verification
REQ-031 Reset: hold rrst_n=0 with rempty=0 and rdata=8'hA5 -> rinc=0, out_valid=0, out_data=0, pop_count=0.
REQ-032 Streaming: FIFO holds 8'h01..8'h04, out_ready=1 -> rinc high 4 consecutive cycles; out_data 01,02,03,04 on consecutive cycles; pop_count=4.
REQ-033 Backpressure: FIFO holds 8'h10..8'h13, out_ready=0 -> exactly 2 rinc pulses, state S_TWO, out_data=8'h10 stable; release out_ready -> 10,11,12,13 delivered in order.
REQ-034 Simultaneous push and pop in S_TWO: head=8'h20, tail=8'h21, rdata=8'h22, out_ready=1 -> next cycle head=8'h21, tail=8'h22, state S_TWO.
REQ-035 Wrap: preload pop_count=16'hFFFE, deliver 3 words -> pop_count sequence FFFF, 0000, 0001.
REQ-036 Mid-operation reset: in S_TWO, pulse rrst_n low between clock edges -> out_valid drops the same timestep, pop_count=0; after release, the next FIFO word is the first delivered.
